note_tone_synth: RTL

- Downstream of the note record/playback datapath: consumes its 32-bit one-hot string/fret note word and produces signed square-wave audio samples for the audio codec interface.
- Latches a note on each note strobe and derives the tone pitch from the string/fret position.
- Applies a simple gate/fade amplitude envelope.
- Delivers samples to the codec with a valid/ready handshake.

---
 rtl/note_tone_synth.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/note_tone_synth.sv
// Square-wave tone synthesiser: latches one-hot string/fret notes, shapes a gate/fade
// envelope and hands signed samples to the codec over a valid/ready handshake.
module note_tone_synth #(
    parameter int unsigned SAMPLE_DIV   = 1042,
    parameter logic [31:0] AMP          = 32'h1000_0000,
    parameter int unsigned DECAY_CYCLES = 2500000,
    parameter int unsigned TONE_SHIFT   = 0  // divides every half period by 2**TONE_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_strobe,
    input  logic [31:0] note_in,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [31:0] sample_data,
    output logic        playing,
    output logic [4:0]  note_idx
);

    localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DecW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StPlay, StFade} state_e;

    // Half period in clk cycles for each note index (50 MHz, equal temperament, A4 = 440 Hz).
    function automatic logic [18:0] half_period(input logic [4:0] idx);
        case (idx)
            5'd0:    return 19'd303373;
            5'd1:    return 19'd227273;
            5'd2:    return 19'd170262;
            5'd3:    return 19'd127553;
            5'd4:    return 19'd101238;
            5'd5:    return 19'd75843;
            5'd6:    return 19'd286346;
            5'd7:    return 19'd214517;
            5'd8:    return 19'd160706;
            5'd9:    return 19'd120394;
            5'd10:   return 19'd95556;
            5'd11:   return 19'd71586;
            5'd12:   return 19'd270274;
            5'd13:   return 19'd202477;
            5'd14:   return 19'd151686;
            5'd15:   return 19'd113636;
            5'd16:   return 19'd90193;
            5'd17:   return 19'd67569;
            5'd18:   return 19'd255105;
            5'd19:   return 19'd191113;
            5'd20:   return 19'd143173;
            5'd21:   return 19'd107258;
            5'd22:   return 19'd85131;
            5'd23:   return 19'd63776;
            5'd24:   return 19'd240787;
            5'd25:   return 19'd180386;
            5'd26:   return 19'd135137;
            5'd27:   return 19'd101238;
            5'd28:   return 19'd80353;
            5'd29:   return 19'd60197;
            default: return 19'd303373;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       amp_q, amp_d;
    logic [DecW-1:0]   decay_cnt_q, decay_cnt_d;
    logic [18:0]       tone_cnt_q, tone_cnt_d;
    logic              phase_q, phase_d;
    logic [4:0]        note_idx_q, note_idx_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic              sample_valid_q, sample_valid_d;
    logic [31:0]       sample_data_q, sample_data_d;

    logic [4:0]  dec_idx;
    logic        note_hit, rest_hit;
    logic [18:0] hp_eff;
    logic        tone_wrap, decay_wrap, tick;
    logic [31:0] amp_half;
    logic        unused_hi;

    assign unused_hi = ^note_in[31:30];

    always_comb begin
        dec_idx = 5'd0;
        for (int i = 29; i >= 0; i--) begin
            if (note_in[i]) dec_idx = 5'(i);
        end
    end

    assign note_hit   = note_strobe && (note_in[29:0] != 30'd0);
    assign rest_hit   = note_strobe && (note_in[29:0] == 30'd0);
    assign hp_eff     = half_period(note_idx_q) >> TONE_SHIFT;
    assign tone_wrap  = (tone_cnt_q == hp_eff - 19'd1);
    assign decay_wrap = (decay_cnt_q == DecW'(DECAY_CYCLES - 1));
    assign tick       = (div_cnt_q == DivW'(SAMPLE_DIV - 1));
    assign amp_half   = {amp_q[31], amp_q[31:1]};

    always_comb begin
        state_d     = state_q;
        amp_d       = amp_q;
        decay_cnt_d = decay_cnt_q;
        note_idx_d  = note_idx_q;
        if (note_hit) note_idx_d = dec_idx;

        case (state_q)
            StIdle: begin
                if (note_hit) begin
                    state_d = StPlay;
                    amp_d   = AMP;
                end
            end
            StPlay: begin
                amp_d = AMP;
                if (rest_hit) begin
                    state_d     = StFade;
                    decay_cnt_d = '0;
                end
            end
            StFade: begin
                if (note_hit) begin
                    state_d = StPlay;
                    amp_d   = AMP;
                end else if (rest_hit) begin
                    // A rest while fading restarts the decay interval without a step.
                    decay_cnt_d = '0;
                end else if (decay_wrap) begin
                    decay_cnt_d = '0;
                    amp_d       = amp_half;
                    if (amp_half == 32'd0) state_d = StIdle;
                end else begin
                    decay_cnt_d = decay_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tone_cnt_d = tone_cnt_q + 19'd1;
        phase_d    = phase_q;
        if (state_q == StIdle || note_hit) begin
            tone_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (tone_wrap) begin
            tone_cnt_d = '0;
            phase_d    = ~phase_q;
        end
    end

    always_comb begin
        div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
        sample_valid_d = sample_valid_q;
        sample_data_d  = sample_data_q;
        if (sample_valid_q && sample_ready) sample_valid_d = 1'b0;
        // Ticks landing on a pending sample are dropped; launch uses pre-strobe state.
        if (tick && !sample_valid_q) begin
            sample_valid_d = 1'b1;
            if (state_q == StIdle) sample_data_d = 32'd0;
            else                   sample_data_d = phase_q ? (32'd0 - amp_q) : amp_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            amp_q          <= '0;
            decay_cnt_q    <= '0;
            tone_cnt_q     <= '0;
            phase_q        <= 1'b0;
            note_idx_q     <= '0;
            div_cnt_q      <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            amp_q          <= amp_d;
            decay_cnt_q    <= decay_cnt_d;
            tone_cnt_q     <= tone_cnt_d;
            phase_q        <= phase_d;
            note_idx_q     <= note_idx_d;
            div_cnt_q      <= div_cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign playing      = (state_q != StIdle);
    assign note_idx     = note_idx_q;

endmodule
